layer1_ch_sched: RTL
====================

// Module: layer1_ch_sched
// PURPOSE
//   Channel scheduler after the layer-1 ReLU bank. Captures the NUM_CH parallel ReLU outputs of
//   each pixel (one pixel per relu_href cycle) into a 2-entry pixel buffer. Replays them as a
//   serial channel stream with valid/ready to the single shared layer-2 MAC/writeback port.
//   Raises stall to the conv front end when the buffer is full.
// PARAMETERS
//   DATA_W   16  ReLU output width per channel
//   NUM_CH   16  channels per pixel (>=2)
//   CNT_W    7   width of h/v pixel counters
//   CH_W     4   channel index width, = clog2(NUM_CH)
// PORTS
//   clk         in   1               clock, all logic rising-edge
//   rst         in   1               synchronous reset, active-high
//   relu_vsync  in   1               frame sync from ReLU bank
//   relu_href   in   1               pixel valid; one pixel per high cycle
//   relu_h_cnt  in   CNT_W           pixel column
//   relu_v_cnt  in   CNT_W           pixel row
//   relu_data   in   NUM_CH*DATA_W   channel c in bits [c*DATA_W +: DATA_W]
//   ser_valid   out  1               output beat valid
//   ser_ready   in   1               downstream accepts beat
//   ser_data    out  DATA_W          channel value
//   ser_ch      out  CH_W            channel index of beat
//   ser_h_cnt   out  CNT_W           column of pixel being sent
//   ser_v_cnt   out  CNT_W           row of pixel being sent
//   ser_last    out  1               final beat of pixel (ch NUM_CH-1)
//   ser_sof     out  1               first beat of pixel h=0,v=0
//   stall       out  1               buffer full; front end must hold href low
//   overflow    out  1               sticky: pixel dropped
// BEHAVIOUR
//   Reset: count=0, wr_ptr=rd_ptr=0, ch_idx=0, overflow=0; ser_valid=0, stall=0.
//     ser_data/ser_ch/cnt outputs=0. Reset mid-pixel discards all buffered data.
//   Capture: href=1 and slot available -> data + h/v written into slot wr_ptr.
//     wr_ptr toggles; count++. Beat visible the next cycle (latency 1 href->ser_valid).
//   ser_valid = (count!=0). Outputs are a mux of slot rd_ptr at ch_idx, registered state only.
//     Beat fields are held stable while valid & !ready.
//   Transfer on ser_valid & ser_ready: ch_idx advances. On last beat: ch_idx=0, rd_ptr toggles,
//     count--.
//   FSM: IDLE (count==0) -> SEND on capture. SEND -> IDLE on last beat with no capture that cycle.
//   stall = (count==2), registered view of count.
//   Simultaneous last-pop and href with count==2: capture accepted into freed slot, count stays 2.
//   Overflow: href with count==2 and no last-pop that cycle -> pixel dropped, overflow <= 1.
//   overflow clears on relu_vsync rising edge; set has priority on the same cycle.
//   vsync does not flush the buffer.
//   Full throughput: NUM_CH beats/pixel; href rate > 1/NUM_CH relies on stall.
// CONFIGURATION
//   LAYER1_ZERO_SKIP_EN defined:
//     - Beats whose channel data==0 are skipped; ch_idx jumps to the next nonzero channel.
//     - Channel NUM_CH-1 is always sent (carries ser_last), even if zero.
//     - All-zero pixel = 1 beat; jump decision is combinational from buffered data.
//   LAYER1_ZERO_SKIP_EN undefined: every channel 0..NUM_CH-1 sent in order.
// STRUCTURE
//   Shared defs file layer1_defs: DATA_W, NUM_CH, CNT_W, CH_W constants; FSM state encodings
//     IDLE=0, SEND=1.
//   Sub-module layer1_pix_buf: 2-entry data+h/v storage with wr_ptr/rd_ptr/count.
//     Exposes full/empty; the scheduler owns ch_idx, FSM and overflow.
// TESTING
//   1. Single pixel h=3,v=5, data ch c = c+1, ready=1:
//      -> 16 beats from cycle+1, ser_ch 0..15, data 1..16, last on ch15, stall stays 0.
//   2. ready toggling 1/0 each cycle on the same pixel:
//      -> ser_data/ser_ch stable during ready=0; 32 cycles total; no beat duplicated or lost.
//   3. href on 3 consecutive cycles, ready=0:
//      -> stall=1 after 2nd capture; 3rd pixel dropped, overflow=1.
//      -> next vsync rise clears overflow.
//   4. count==2, ready=1, href on the exact cycle ch15 of the oldest pixel pops:
//      -> capture accepted, overflow=0, pixels emerge in arrival order.
//   5. Pixel h=0,v=0 -> ser_sof=1 on ch0 beat only.
//      Assert rst mid-pixel at ch7 -> next cycle ser_valid=0, stall=0, overflow=0.
//   6. ZERO_SKIP_EN, data nonzero only on ch2 and ch9:
//      -> beats ch2, ch9, ch15 (data 0, last).
//      -> all-zero pixel gives single ch15 beat.

Source files
------------

// File: rtl/layer1_ch_sched_pkg.sv
// layer1_ch_sched_pkg: shared sizes and FSM encoding for the layer-1 channel scheduler
package layer1_ch_sched_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 16;
  localparam int CNT_W = 7;
  localparam int CH_W = 4;
  localparam int PIX_W = NUM_CH * DATA_W;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
endpackage

// File: rtl/layer1_pix_buf.sv
// layer1_pix_buf: 2-entry pixel store (all channels plus h/v) with write/read pointers and occupancy
module layer1_pix_buf
  import layer1_ch_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic [CNT_W-1:0] wr_h_i,
  input  logic [CNT_W-1:0] wr_v_i,
  input  logic             rd_pop_i,
  output logic [PIX_W-1:0] rd_data_o,
  output logic [CNT_W-1:0] rd_h_o,
  output logic [CNT_W-1:0] rd_v_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [PIX_W-1:0] data_q [2];
  logic [CNT_W-1:0] h_q [2];
  logic [CNT_W-1:0] v_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  always_comb count_d = count_q + {1'b0, wr_en_i} - {1'b0, rd_pop_i};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (wr_en_i) begin
        data_q[wr_ptr_q] <= wr_data_i;
        h_q[wr_ptr_q] <= wr_h_i;
        v_q[wr_ptr_q] <= wr_v_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (rd_pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end
  assign rd_data_o = data_q[rd_ptr_q];
  assign rd_h_o = h_q[rd_ptr_q];
  assign rd_v_o = v_q[rd_ptr_q];
  assign full_o = count_q == 2'd2;
  assign empty_o = count_q == 2'd0;
endmodule

// File: rtl/layer1_ch_sched.sv
// layer1_ch_sched: buffers parallel ReLU pixels and replays them as a serial channel stream.
// LAYER1_ZERO_SKIP_EN: skip zero-valued channels except the last one.
module layer1_ch_sched
  import layer1_ch_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              relu_vsync,
  input  logic              relu_href,
  input  logic [CNT_W-1:0]  relu_h_cnt,
  input  logic [CNT_W-1:0]  relu_v_cnt,
  input  logic [PIX_W-1:0]  relu_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic [DATA_W-1:0] ser_data,
  output logic [CH_W-1:0]   ser_ch,
  output logic [CNT_W-1:0]  ser_h_cnt,
  output logic [CNT_W-1:0]  ser_v_cnt,
  output logic              ser_last,
  output logic              ser_sof,
  output logic              stall,
  output logic              overflow
);
  logic [PIX_W-1:0] pix;
  logic [CH_W-1:0]  ch_idx_q, eff_ch;
  logic             full, empty, xfer, pop, cap, ovf_set, overflow_q, vsync_q;
  state_e           state_q;
  layer1_pix_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (cap),
    .wr_data_i(relu_data),
    .wr_h_i   (relu_h_cnt),
    .wr_v_i   (relu_v_cnt),
    .rd_pop_i (pop),
    .rd_data_o(pix),
    .rd_h_o   (ser_h_cnt),
    .rd_v_o   (ser_v_cnt),
    .full_o   (full),
    .empty_o  (empty)
  );
`ifdef LAYER1_ZERO_SKIP_EN
  // first nonzero channel at or after ch_idx_q; last channel is the fallback
  always_comb begin
    eff_ch = CH_W'(NUM_CH - 1);
    for (int c = NUM_CH - 2; c >= 0; c--)
      if (CH_W'(c) >= ch_idx_q && pix[c*DATA_W +: DATA_W] != '0) eff_ch = CH_W'(c);
  end
`else
  always_comb eff_ch = ch_idx_q;
`endif
  assign ser_valid = (state_q == SEND) & ~empty;
  assign ser_data = pix[eff_ch*DATA_W +: DATA_W];
  assign ser_ch = ser_valid ? eff_ch : '0;
  assign ser_last = ser_valid & (eff_ch == CH_W'(NUM_CH - 1));
  assign ser_sof = ser_valid & (ch_idx_q == '0) & (ser_h_cnt == '0) & (ser_v_cnt == '0);
  assign xfer = ser_valid & ser_ready;
  assign pop = xfer & ser_last;
  assign cap = relu_href & (~full | pop);
  assign ovf_set = relu_href & ~cap;
  assign stall = full;
  assign overflow = overflow_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_idx_q <= '0;
      overflow_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= relu_vsync;
      overflow_q <= ovf_set | (overflow_q & ~(relu_vsync & ~vsync_q));
      ch_idx_q <= pop ? '0 : xfer ? eff_ch + 1'b1 : ch_idx_q;
      state_q <= cap ? SEND : (pop & ~full) ? IDLE : state_q;
    end
  end
endmodule
